mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit with HI/LO registers; sits in EX beside the ALU.
//  Executes mult/multu/div/divu/madd/maddu/msub/msubu with a fixed per-class latency, plus mthi/mtlo.
//  Raises busy so the hazard unit stalls md-class instructions.
//  Exposes HI/LO directly for mfhi/mflo.
// PARAMETERS
//  WIDTH    32  operand width; HI and LO are each WIDTH bits
//  MUL_LAT  5   cycles busy for mult/multu/madd*/msub*; must be >=1
//  DIV_LAT  10  cycles busy for div/divu; must be >=1
// PORTS
//  clk      in   1      system clock, rising edge
//  reset    in   1      synchronous, active-high
//  start    in   1      EX instruction is md-class; sampled with op/A/B
//  flush    in   1      exception/interrupt this cycle; suppresses start
//  op       in   4      `MDU_* opcode
//  A        in   WIDTH  rs operand
//  B        in   WIDTH  rt operand
//  busy     out  1      long operation in flight
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
// BEHAVIOUR
//  Reset: hi=0, lo=0, busy=0, counter=0, pending results=0. Reset mid-operation aborts it; HI/LO stay 0.
//  Accept: start=1 & flush=0 & busy=0 at edge t.
//   Long ops: compute the result from A/B (and HI/LO for madd/msub) at t into pending regs.
//   Load counter with MUL_LAT or DIV_LAT.
//  busy = (counter!=0), driven straight from the register, so there is no combinational start->busy path.
//  Counter decrements each edge. At the edge where counter==1, commit pending regs to HI/LO and counter becomes 0.
//   So busy is high for exactly LAT cycles after t. New HI/LO are visible the cycle busy falls.
//  mthi/mtlo: single-cycle. At edge t, hi<=A or lo<=A; busy stays 0.
//  start while busy=1: ignored (the hazard unit must prevent it). An in-flight op is not disturbed.
//  start with flush=1: ignored entirely, no state change. flush never cancels an in-flight op.
//  op = `MDU_NONE or unknown with start=1: no effect.
//  Arithmetic:
//   mult (signed) / multu (unsigned): 2*WIDTH product; {hi,lo} = product.
//   madd(u)/msub(u): {hi,lo} <= {hi,lo} +/- product, modulo 2^(2*WIDTH). HI/LO are sampled at acceptance.
//   div/divu: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
//   Signed MIN/-1: lo=MIN, hi=0 (wrap, no trap).
//   Divide by zero: op still takes DIV_LAT cycles; HI/LO unchanged at commit.
//  No overflow output; the unit never raises exceptions.
// STRUCTURE
//  header.v gains:
//   `MDU_NONE 0, `MDU_MULT 1, `MDU_MULTU 2, `MDU_DIV 3, `MDU_DIVU 4,
//   `MDU_MTHI 5, `MDU_MTLO 6, `MDU_MADD 7, `MDU_MADDU 8, `MDU_MSUB 9, `MDU_MSUBU 10.
//  One combinational sub-module, mdu_calc (op, A, B, hi, lo -> new_hi, new_lo), isolates the arithmetic.
//  This module keeps the counter, pending regs, HI/LO and the accept logic.
// TESTING
//  1. mult: A=-3 (FFFFFFFD), B=7 -> busy high 5 cycles; then hi=FFFFFFFF, lo=FFFFFFEB.
//  2. divu: A=100, B=7 -> busy high 10 cycles; then lo=14, hi=2.
//     div: A=-7, B=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//  3. div 80000000/FFFFFFFF -> lo=80000000, hi=0.
//     div by 0 with hi=5, lo=6 preset -> after 10 cycles hi=5, lo=6.
//  4. mthi A=1234 -> hi=1234 next cycle, busy never rises.
//     mult, then start again at cycle 2 of busy -> second start ignored; first result commits intact.
//  5. start mult with flush=1 -> busy stays 0, HI/LO unchanged.
//     reset at cycle 3 of a div -> busy=0, hi=lo=0 next cycle; no later commit.
//  6. hi=0, lo=FFFFFFFF, maddu A=1, B=1 -> hi=1, lo=0.
//     msub on hi=lo=0 with A=1, B=1 -> hi=lo=FFFFFFFF.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Opcodes and operation classes shared by the multiply/divide unit and its arithmetic core.
// The opcode values match the MDU_* encoding the decoder emits.
package mul_div_unit_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;
  localparam logic [3:0] MDU_MSUB  = 4'd9;
  localparam logic [3:0] MDU_MSUBU = 4'd10;

  typedef enum logic [1:0] {
    MD_CLASS_NONE,
    MD_CLASS_MUL,
    MD_CLASS_DIV,
    MD_CLASS_MOVE
  } md_class_e;

  // Groups opcodes by how long they occupy the unit; unknown codes are NONE.
  function automatic md_class_e md_class(input logic [3:0] op);
    md_class_e c;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: c = MD_CLASS_MUL;
      MDU_DIV, MDU_DIVU:                                             c = MD_CLASS_DIV;
      MDU_MTHI, MDU_MTLO:                                            c = MD_CLASS_MOVE;
      default:                                                       c = MD_CLASS_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mul_div_unit_calc.sv
// Purely combinational arithmetic core: given the opcode, operands and the current HI/LO,
// produce the HI/LO values the operation would leave behind.
module mdu_calc
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] new_hi,
  output logic [WIDTH-1:0] new_lo
);

  logic                 mul_signed;
  logic [2*WIDTH-1:0]   ext_a;
  logic [2*WIDTH-1:0]   ext_b;
  logic [2*WIDTH-1:0]   product;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   result;

  logic                 div_signed;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH-1:0]     b_safe;
  logic [WIDTH-1:0]     q_mag;
  logic [WIDTH-1:0]     r_mag;
  logic [WIDTH-1:0]     quot;
  logic [WIDTH-1:0]     rem;

  // Sign- or zero-extending to 2*WIDTH makes the truncated product correct for both flavours.
  always_comb begin
    mul_signed = (op == MDU_MULT) || (op == MDU_MADD) || (op == MDU_MSUB);
    ext_a      = mul_signed ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
    ext_b      = mul_signed ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
    product    = ext_a * ext_b;
    acc        = {hi, lo};
  end

  // Divide on magnitudes, then restore signs; MIN/-1 wraps back to MIN with remainder 0.
  always_comb begin
    div_signed = (op == MDU_DIV);
    a_neg      = div_signed & A[WIDTH-1];
    b_neg      = div_signed & B[WIDTH-1];
    a_mag      = a_neg ? (~A + 1'b1) : A;
    b_mag      = b_neg ? (~B + 1'b1) : B;
    b_safe     = (B == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    quot       = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    rem        = a_neg ? (~r_mag + 1'b1) : r_mag;
  end

  always_comb begin
    result = acc;
    case (op)
      MDU_MULT, MDU_MULTU: result = product;
      MDU_MADD, MDU_MADDU: result = acc + product;
      MDU_MSUB, MDU_MSUBU: result = acc - product;
      MDU_DIV, MDU_DIVU: begin
        if (B != '0) begin
          result = {rem, quot};
        end
      end
      MDU_MTHI: result = {A, lo};
      MDU_MTLO: result = {hi, A};
      default:  result = acc;
    endcase
    new_hi = result[2*WIDTH-1:WIDTH];
    new_lo = result[WIDTH-1:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO. Results are computed at acceptance, held in
// pending registers and committed when the latency counter expires; busy is the counter state.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] pend_hi_reg;
  logic [WIDTH-1:0] pend_lo_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] calc_hi;
  logic [WIDTH-1:0] calc_lo;
  logic             idle;
  logic             accept;
  md_class_e        op_class;

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op     (op),
    .A      (A),
    .B      (B),
    .hi     (hi_reg),
    .lo     (lo_reg),
    .new_hi (calc_hi),
    .new_lo (calc_lo)
  );

  assign idle     = (cnt_reg == '0);
  assign accept   = start & ~flush & idle;
  assign op_class = md_class(op);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg     <= '0;
      pend_hi_reg <= '0;
      pend_lo_reg <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else if (accept) begin
      case (op_class)
        MD_CLASS_MUL: begin
          pend_hi_reg <= calc_hi;
          pend_lo_reg <= calc_lo;
          cnt_reg     <= CNT_W'(MUL_LAT);
        end
        MD_CLASS_DIV: begin
          pend_hi_reg <= calc_hi;
          pend_lo_reg <= calc_lo;
          cnt_reg     <= CNT_W'(DIV_LAT);
        end
        MD_CLASS_MOVE: begin
          hi_reg <= calc_hi;
          lo_reg <= calc_lo;
        end
        default: begin
        end
      endcase
    end else if (!idle) begin
      // The last busy cycle is also the commit edge.
      cnt_reg <= cnt_reg - CNT_W'(1);
      if (cnt_reg == CNT_W'(1)) begin
        hi_reg <= pend_hi_reg;
        lo_reg <= pend_lo_reg;
      end
    end
  end

  assign busy = !idle;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
